// File: rtl/alu_operand_stage_if.sv
// ALU operand stage: shared op encodings and the stage bus.
// Ports: decoded instruction, forwarding buses, registered operands out.
package alu_operand_pkg;
  localparam logic [3:0] ALU_ADDU = 4'd0;
  localparam logic [3:0] ALU_SUBU = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;
  localparam logic [3:0] ALU_ADD  = 4'd12;
  localparam logic [3:0] ALU_SUB  = 4'd13;
endpackage

interface alu_operand_stage_if;
  logic        in_valid;
  logic        stall;
  logic        flush;
  logic [3:0]  alu_op_in;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [15:0] imm16;
  logic [4:0]  shamt;
  logic        use_imm;
  logic        imm_sext;
  logic        shift_var;
  logic [4:0]  rd_addr_in;
  logic        reg_write_in;
  logic        ex_fwd_valid;
  logic [4:0]  ex_fwd_addr;
  logic [31:0] ex_fwd_data;
  logic        ex_fwd_is_load;
  logic        wb_fwd_valid;
  logic [4:0]  wb_fwd_addr;
  logic [31:0] wb_fwd_data;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  ALUop;
  logic        out_valid;
  logic [4:0]  rd_addr_out;
  logic        reg_write_out;
  logic        stall_req;

  modport slave (
    input  in_valid, stall, flush, alu_op_in,
    input  rs_addr, rt_addr, rs_data, rt_data,
    input  imm16, shamt, use_imm, imm_sext,
    input  shift_var, rd_addr_in, reg_write_in,
    input  ex_fwd_valid, ex_fwd_addr,
    input  ex_fwd_data, ex_fwd_is_load,
    input  wb_fwd_valid, wb_fwd_addr, wb_fwd_data,
    output A, B, ALUop, out_valid,
    output rd_addr_out, reg_write_out, stall_req
  );

  modport master (
    output in_valid, stall, flush, alu_op_in,
    output rs_addr, rt_addr, rs_data, rt_data,
    output imm16, shamt, use_imm, imm_sext,
    output shift_var, rd_addr_in, reg_write_in,
    output ex_fwd_valid, ex_fwd_addr,
    output ex_fwd_data, ex_fwd_is_load,
    output wb_fwd_valid, wb_fwd_addr, wb_fwd_data,
    input  A, B, ALUop, out_valid,
    input  rd_addr_out, reg_write_out, stall_req
  );
endinterface

// File: rtl/alu_operand_stage.sv
// ALU operand stage: forwards rs/rt, selects A/B, detects load-use.
// Ports: clk, rst_n, bus (slave) carrying instruction, fwd and outputs.
module alu_operand_stage
  import alu_operand_pkg::*;
(
  input logic clk,
  input logic rst_n,
  alu_operand_stage_if.slave bus
);

  logic [31:0] rs_fwd;
  logic [31:0] rt_fwd;
  logic [31:0] imm_ext;
  logic [31:0] a_nxt;
  logic [31:0] b_nxt;
  logic        is_shift;
  logic        is_lui;
  logic        rs_used;
  logic        rt_used;
  logic        ld_hit;

  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [3:0]  op_q;
  logic [4:0]  rd_q;
  logic        v_q;
  logic        rw_q;

  // EX result is younger than WB, so it wins; r0 is never forwarded.
  function automatic logic [31:0] fwd(
    input logic [4:0]  ad,
    input logic [31:0] rf
  );
    logic [31:0] r;
    r = rf;
    if (ad != 5'd0) begin
      if (bus.ex_fwd_valid && bus.ex_fwd_addr == ad)
        r = bus.ex_fwd_data;
      else if (bus.wb_fwd_valid && bus.wb_fwd_addr == ad)
        r = bus.wb_fwd_data;
    end
    return r;
  endfunction

  always_comb begin
    rs_fwd = fwd(bus.rs_addr, bus.rs_data);
    rt_fwd = fwd(bus.rt_addr, bus.rt_data);
  end

  always_comb begin
    is_lui   = bus.alu_op_in == ALU_LUI;
    is_shift = bus.alu_op_in == ALU_SLL
            || bus.alu_op_in == ALU_SRL
            || bus.alu_op_in == ALU_SRA;
    imm_ext  = {{16{bus.imm_sext & bus.imm16[15]}}, bus.imm16};
    a_nxt    = rs_fwd;
    b_nxt    = bus.use_imm ? imm_ext : rt_fwd;
    unique case (1'b1)
      is_lui: begin
        a_nxt = {16'd0, bus.imm16};
        b_nxt = 32'd16;
      end
      is_shift: begin
        a_nxt = rt_fwd;
        b_nxt = {27'd0, bus.shift_var
                        ? rs_fwd[4:0] : bus.shamt};
      end
      default: ;
    endcase
  end

  // Which sources the instruction actually reads.
  always_comb begin
    rs_used = !is_lui && (!is_shift || bus.shift_var);
    rt_used = is_shift || (!is_lui && !bus.use_imm);
    ld_hit  = bus.in_valid && bus.ex_fwd_valid
           && bus.ex_fwd_is_load
           && bus.ex_fwd_addr != 5'd0;
  end

  assign bus.stall_req = ld_hit
    && ((rs_used && bus.ex_fwd_addr == bus.rs_addr)
     || (rt_used && bus.ex_fwd_addr == bus.rt_addr));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= 32'd0;
      b_q  <= 32'd0;
      op_q <= ALU_ADDU;
      rd_q <= 5'd0;
      v_q  <= 1'b0;
      rw_q <= 1'b0;
    end else if (bus.flush) begin
      v_q  <= 1'b0;
      rw_q <= 1'b0;
    end else if (bus.stall) begin
      v_q  <= v_q;
    end else if (bus.stall_req) begin
      v_q  <= 1'b0;
      rw_q <= 1'b0;
    end else begin
      a_q  <= a_nxt;
      b_q  <= b_nxt;
      op_q <= bus.alu_op_in;
      rd_q <= bus.rd_addr_in;
      v_q  <= bus.in_valid;
      rw_q <= bus.in_valid & bus.reg_write_in;
    end
  end

  assign bus.A             = a_q;
  assign bus.B             = b_q;
  assign bus.ALUop         = op_q;
  assign bus.rd_addr_out   = rd_q;
  assign bus.out_valid     = v_q;
  assign bus.reg_write_out = rw_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage.
// Directed cases then random traffic against a reference model.
module tb_alu_operand_stage;
  import alu_operand_pkg::*;

  typedef struct {
    logic        iv, st, fl;
    logic [3:0]  op;
    logic [4:0]  rsa, rta;
    logic [31:0] rsd, rtd;
    logic [15:0] imm;
    logic [4:0]  sh;
    logic        ui, sx, sv;
    logic [4:0]  rd;
    logic        rw;
    logic        exv;
    logic [4:0]  exa;
    logic [31:0] exd;
    logic        exl;
    logic        wbv;
    logic [4:0]  wba;
    logic [31:0] wbd;
  } stim_t;

  typedef struct {
    logic        sr;
    logic [31:0] a, b;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        v, rw;
  } exp_t;

  logic clk;
  logic rst_n;
  alu_operand_stage_if bus ();

  alu_operand_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int   nvec = 0;
  int   nbad = 0;
  exp_t q[$];
  exp_t m;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    s.op = ALU_ADDU;
    return s;
  endfunction

  function automatic logic [31:0] rd_src(stim_t s,
    logic [4:0] ad, logic [31:0] d);
    if (ad == 0) return d;
    if (s.exv && s.exa == ad) return s.exd;
    if (s.wbv && s.wba == ad) return s.wbd;
    return d;
  endfunction

  function automatic void model_reset();
    m = '{default: '0};
    m.op = ALU_ADDU;
  endfunction

  task automatic drive(stim_t s);
    bus.in_valid       = s.iv;
    bus.stall          = s.st;
    bus.flush          = s.fl;
    bus.alu_op_in      = s.op;
    bus.rs_addr        = s.rsa;
    bus.rt_addr        = s.rta;
    bus.rs_data        = s.rsd;
    bus.rt_data        = s.rtd;
    bus.imm16          = s.imm;
    bus.shamt          = s.sh;
    bus.use_imm        = s.ui;
    bus.imm_sext       = s.sx;
    bus.shift_var      = s.sv;
    bus.rd_addr_in     = s.rd;
    bus.reg_write_in   = s.rw;
    bus.ex_fwd_valid   = s.exv;
    bus.ex_fwd_addr    = s.exa;
    bus.ex_fwd_data    = s.exd;
    bus.ex_fwd_is_load = s.exl;
    bus.wb_fwd_valid   = s.wbv;
    bus.wb_fwd_addr    = s.wba;
    bus.wb_fwd_data    = s.wbd;
  endtask

  // Reference: what the stage should hold after the coming edge.
  task automatic predict(stim_t s);
    logic        shift, lui, rsu, rtu, hz;
    logic [31:0] rsv, rtv, na, nb;
    exp_t        e;
    shift = (s.op == ALU_SLL) || (s.op == ALU_SRL)
         || (s.op == ALU_SRA);
    lui   = (s.op == ALU_LUI);
    rsv   = rd_src(s, s.rsa, s.rsd);
    rtv   = rd_src(s, s.rta, s.rtd);
    if (lui) begin
      na = 32'(s.imm);
      nb = 16;
    end else if (shift) begin
      na = rtv;
      nb = s.sv ? rsv % 32 : 32'(s.sh);
    end else begin
      na = rsv;
      if (!s.ui) nb = rtv;
      else if (s.sx && s.imm >= 16'h8000)
        nb = 32'hFFFF_0000 + 32'(s.imm);
      else nb = 32'(s.imm);
    end
    rsu = !lui && (!shift || s.sv);
    rtu = shift || (!lui && !s.ui);
    hz  = s.iv && s.exv && s.exl && s.exa != 0
       && ((rsu && s.exa == s.rsa)
        || (rtu && s.exa == s.rta));
    if (s.fl) begin
      m.v  = 0;
      m.rw = 0;
    end else if (s.st) begin
      m.v = m.v;
    end else if (hz) begin
      m.v  = 0;
      m.rw = 0;
    end else begin
      m.a  = na;
      m.b  = nb;
      m.op = s.op;
      m.rd = s.rd;
      m.v  = s.iv;
      m.rw = s.iv & s.rw;
    end
    e    = m;
    e.sr = hz;
    q.push_back(e);
  endtask

  task automatic apply(stim_t s);
    @(negedge clk);
    drive(s);
    predict(s);
  endtask

  // Monitor: stall_req checked just before the edge, regs after.
  initial begin
    exp_t  e;
    logic  sr;
    forever begin
      @(posedge clk);
      if (q.size() > 0) begin
        e  = q.pop_front();
        sr = bus.stall_req;
        #1;
        chk("stall_req", 32'(sr), 32'(e.sr));
        chk("out_valid", 32'(bus.out_valid), 32'(e.v));
        chk("reg_write", 32'(bus.reg_write_out), 32'(e.rw));
        if (e.v) begin
          chk("A", bus.A, e.a);
          chk("B", bus.B, e.b);
          chk("ALUop", 32'(bus.ALUop), 32'(e.op));
          chk("rd_addr", 32'(bus.rd_addr_out), 32'(e.rd));
        end
      end
    end
  end

  task automatic chk_reset(string tag);
    chk({tag, " A"}, bus.A, 32'd0);
    chk({tag, " B"}, bus.B, 32'd0);
    chk({tag, " ALUop"}, 32'(bus.ALUop), 32'(ALU_ADDU));
    chk({tag, " rd"}, 32'(bus.rd_addr_out), 32'd0);
    chk({tag, " rw"}, 32'(bus.reg_write_out), 32'd0);
    chk({tag, " v"}, 32'(bus.out_valid), 32'd0);
  endtask

  stim_t s;

  initial begin
    model_reset();
    drive(idle());
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2 chk_reset("rst");

    // First capture on the first edge after release.
    @(negedge clk);
    s = idle();
    s.iv = 1; s.rsa = 5; s.rsd = 7; s.rta = 6;
    s.rtd = 9; s.rd = 2; s.rw = 1;
    rst_n = 1'b1;
    drive(s);
    predict(s);

    // Forward priority and r0.
    s = idle();
    s.iv = 1; s.rsa = 3; s.rsd = 32'h55;
    s.exv = 1; s.exa = 3; s.exd = 32'h11;
    s.wbv = 1; s.wba = 3; s.wbd = 32'h22;
    apply(s);
    s.rsa = 0; s.exa = 0; s.rsd = 32'h99;
    apply(s);

    // Immediate extension and LUI.
    s = idle();
    s.iv = 1; s.ui = 1; s.imm = 16'hFFFC; s.sx = 1;
    apply(s);
    s.sx = 0;
    apply(s);
    s.op = ALU_LUI; s.imm = 16'h1234;
    apply(s);

    // Shifts.
    s = idle();
    s.iv = 1; s.op = ALU_SRA; s.sv = 1; s.rsa = 4;
    s.exv = 1; s.exa = 4; s.exd = 32'h25;
    apply(s);
    s = idle();
    s.iv = 1; s.op = ALU_SLL; s.sh = 31; s.rta = 7;
    s.rtd = 32'hA5A5_0001;
    apply(s);

    // Load-use bubble then capture from WB.
    s = idle();
    s.iv = 1; s.rsa = 1; s.rsd = 3; s.rta = 8;
    s.rtd = 4; s.rd = 9; s.rw = 1;
    s.exv = 1; s.exa = 8; s.exl = 1; s.exd = 32'h77;
    apply(s);
    s.exv = 0; s.wbv = 1; s.wba = 8; s.wbd = 32'hCAFE;
    apply(s);

    // Stall holds, flush wins over stall.
    s = idle();
    s.iv = 1; s.rsa = 2; s.rsd = 32'h1357; s.rd = 4;
    s.rw = 1; s.op = ALU_SUBU;
    apply(s);
    s.st = 1;
    s.rsd = 32'hDEAD;
    s.exv = 1; s.exa = 2; s.exd = 32'hBEEF;
    repeat (3) apply(s);
    s.fl = 1;
    apply(s);

    // Reset in the middle of a stall.
    s = idle();
    s.iv = 1; s.rsd = 32'h2468; s.rw = 1; s.rd = 3;
    apply(s);
    s.st = 1;
    apply(s);
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk_reset("midstall");
    model_reset();
    @(negedge clk);
    drive(idle());
    rst_n = 1'b1;
    predict(idle());

    for (int i = 0; i < 400; i++) begin
      s.iv  = 1'($urandom_range(0, 3) != 0);
      s.st  = 1'($urandom_range(0, 4) == 0);
      s.fl  = 1'($urandom_range(0, 9) == 0);
      s.op  = 4'($urandom_range(0, 13));
      s.rsa = 5'($urandom_range(0, 3));
      s.rta = 5'($urandom_range(0, 3));
      s.rsd = $urandom;
      s.rtd = $urandom;
      s.imm = 16'($urandom);
      s.sh  = 5'($urandom);
      s.ui  = 1'($urandom);
      s.sx  = 1'($urandom);
      s.sv  = 1'($urandom);
      s.rd  = 5'($urandom);
      s.rw  = 1'($urandom);
      s.exv = 1'($urandom);
      s.exa = 5'($urandom_range(0, 3));
      s.exd = $urandom;
      s.exl = 1'($urandom_range(0, 2) == 0);
      s.wbv = 1'($urandom);
      s.wba = 5'($urandom_range(0, 3));
      s.wbd = $urandom;
      apply(s);
    end

    for (int i = 0; i < 10 && q.size() > 0; i++)
      @(posedge clk);
    #2;
    if (q.size() > 0) begin
      nbad++;
      $display("FAIL drain: %0d left, need 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nbad);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 The block SHALL have the following ports, all inputs sampled on the rising clock edge unless stated otherwise:
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  decoded instruction present.
- stall  in  1  downstream hold.
- flush  in  1  kill the instruction being captured.
- alu_op_in  in  4  ALUop code, encodings from ALUop.vh.
- rs_addr, rt_addr  in  5 each  source register numbers.
- rs_data, rt_data  in  32 each  register-file read data.
- imm16  in  16  instruction immediate.
- shamt  in  5  instruction shift amount.
- use_imm  in  1  B from immediate.
- imm_sext  in  1  1 = sign-extend imm16, 0 = zero-extend.
- shift_var  in  1  shift amount from rs[4:0] instead of shamt.
- rd_addr_in  in  5  destination register.
- reg_write_in  in  1  instruction writes rd.
- ex_fwd_valid, ex_fwd_addr[4:0], ex_fwd_data[31:0], ex_fwd_is_load  in  execute/memory-stage result bus.
- wb_fwd_valid, wb_fwd_addr[4:0], wb_fwd_data[31:0]  in  writeback result bus.
- A, B  out  32 each  registered ALU operands.
- ALUop  out  4  registered ALU operation.
- out_valid  out  1  registered stage-valid.
- rd_addr_out  out  5  registered destination register.
- reg_write_out  out  1  registered write enable, gated by valid.
- stall_req  out  1  combinational load-use hazard request to upstream.

Function
REQ-002 Forwarded rs value SHALL be selected in this order:
- ex_fwd_data if ex_fwd_valid, ex_fwd_addr==rs_addr and rs_addr!=0;
- else wb_fwd_data on the equivalent wb match;
- else rs_data.
- The same rule SHALL apply to rt.
REQ-003 Register 0 SHALL never be forwarded; it SHALL read rs_data/rt_data unchanged.
REQ-004 Operand select for ALU_LUI: A={16'b0,imm16}, B=32'd16.
REQ-005 Operand select for ALU_SLL/ALU_SRL/ALU_SRA: A=fwd rt; B={27'b0, shift_var ? fwd rs[4:0] : shamt}.
REQ-006 Operand select for all other ops: A=fwd rs; B = use_imm ? extended imm16 (per imm_sext) : fwd rt.
REQ-007 stall_req SHALL be 1 when all of the following hold: in_valid, ex_fwd_valid, ex_fwd_is_load, ex_fwd_addr!=0, and ex_fwd_addr equals rs_addr (used as a source) or rt_addr (used as a source: shifts, or non-LUI with use_imm=0).
REQ-008 Capture priority per rising edge:
- flush -> out_valid=0, reg_write_out=0;
- else stall -> all outputs hold;
- else stall_req -> bubble: out_valid=0, reg_write_out=0, other outputs hold;
- else capture operands, ALUop=alu_op_in, rd_addr_out=rd_addr_in, out_valid=in_valid, reg_write_out=in_valid&reg_write_in.
REQ-009 Latency SHALL be exactly one cycle from capture to operands at A/B.
REQ-010 Forwarding SHALL be resolved only at capture; held outputs SHALL NOT re-forward during stall.
REQ-011 flush together with stall SHALL clear out_valid (flush wins).
REQ-012 An invalid instruction (in_valid=0) captured SHALL produce out_valid=0 and reg_write_out=0; A, B and ALUop SHALL still update (don't-care contents).

Reset
REQ-013 rst_n low SHALL immediately set A=0, B=0, ALUop=ALU_ADDU, rd_addr_out=0, reg_write_out=0, out_valid=0, independent of clk.
REQ-014 Reset asserted mid-stall or mid-bubble SHALL discard the held instruction.
REQ-015 The first capture SHALL occur on the first rising edge after rst_n deasserts.

Verification
REQ-016 ADDU: rs=5 (rs_data=7), rt=6 (rt_data=9), no forwarding -> next cycle A=7, B=9, out_valid=1.
REQ-017 ex and wb both match rs=3 (ex data 0x11, wb data 0x22) -> A=0x11; rs=0 with ex_fwd_addr=0 -> A=rs_data.
REQ-018 ADDU with imm16=0xFFFC: imm_sext=1 -> B=0xFFFFFFFC; imm_sext=0 -> B=0x0000FFFC. LUI imm16=0x1234 -> A=0x1234, B=16.
REQ-019 SRA with shift_var=1, rs fwd value 0x25 -> B=5. SLL with shamt=31 -> B=31, A=fwd rt.
REQ-020 Load in EX with ex_fwd_addr=rt_addr=8 and use_imm=0 -> stall_req=1, next out_valid=0, outputs otherwise held; when the load moves to wb, the instruction captures with A/B from wb_fwd_data.
REQ-021 Capture, stall 3 cycles, then flush+stall together -> outputs constant for 3 cycles, then out_valid=0. Assert rst_n low mid-stall -> all outputs equal their REQ-013 values before the next edge.
